// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types and constants for the data-memory responder and its storage
// array: the responder state enum, the data and byte-enable widths, the wait
// counter width, and the address-error rule used when a request is judged.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // A request is in error when the byte address is not word aligned or the
  // word index falls beyond the end of the array.
  function automatic logic addrIsBad(input logic [31:0] addr,
                                     input int unsigned depthWords);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depthWords));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-organised storage for the responder: one synchronous write port with
// per-byte enables and one combinational read port. Contents are not reset.
//
// Ports
//   clk       : clock, write happens on the rising edge
//   i_wrEn    : write strobe
//   i_wrAddr  : word index to write
//   i_wrData  : write data word
//   i_wrBe    : byte enables, bit b selects i_wrData[8b+7:8b]
//   i_rdAddr  : word index to read
//   o_rdData  : word currently stored at i_rdAddr
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_wrEn,
  input  logic [AW-1:0]     i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [BE_W-1:0]   i_wrBe,
  input  logic [AW-1:0]     i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  // Byte-lane write: lanes whose enable is low keep their previous contents,
  // which is what lets partial stores merge with the existing word.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_wrBe[b]) begin
          r_mem[i_wrAddr][8*b +: 8] <= i_wrData[8*b +: 8];
        end
      end
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder for a simple processor. A request
// is accepted in IDLE, optionally waits LATENCY cycles in WAIT, then performs
// the store (or samples the load word) on the edge that enters RESP, and holds
// the response until the processor takes it.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   req_valid  : request present
//   req_ready  : responder idle and able to accept
//   req_we     : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   req_be     : store byte enables
//   rsp_valid  : response present
//   rsp_ready  : processor takes the response
//   rsp_rdata  : load data, 0 for stores and errors
//   rsp_err    : request was misaligned or out of range
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_reqReady;
  logic              r_rspValid;
  logic [DATA_W-1:0] r_rspRdata;
  logic              r_rspErr;

  logic              w_accept;
  logic              w_enterResp;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_be;
  logic              w_err;
  logic              w_wrEn;
  logic [DATA_W-1:0] w_rdData;

  assign w_accept = req_valid && (r_state == IDLE);

  // With zero latency the response is formed on the acceptance edge itself,
  // before the request has been captured, so the live inputs are used in IDLE
  // and the captured copy everywhere else.
  assign w_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_be    = (r_state == IDLE) ? req_be    : r_be;

  assign w_enterResp = ((r_state == IDLE) && w_accept && (LATENCY == 0)) ||
                       ((r_state == WAIT) && (r_cnt == '0));

  assign w_err = addrIsBad(w_addr, DEPTH_WORDS);

  // A reset landing on the RESP-entry edge must not leave a write behind.
  assign w_wrEn = w_enterResp && w_we && !w_err && !reset;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk      (clk),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (w_addr[AW+1:2]),
    .i_wrData (w_wdata),
    .i_wrBe   (w_be),
    .i_rdAddr (w_addr[AW+1:2]),
    .o_rdData (w_rdData)
  );

  // Responder FSM. All outputs are registered; the response fields are loaded
  // once on entry to RESP and then simply held until the processor takes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_be       <= req_be;
            r_reqReady <= 1'b0;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state    <= IDLE;
            r_reqReady <= 1'b1;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_reqReady <= 1'b1;
        end
      endcase

      if (w_enterResp) begin
        r_rspValid <= 1'b1;
        r_rspErr   <= w_err;
        r_rspRdata <= (w_we || w_err) ? '0 : w_rdData;
      end
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule
